// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   - Debounce FSM state encoding (IDLE, PRESSED).
//   - Scan result record {valid, code} and its "no key" value.
//   - Printed-legend lookup table, indexed by the raw {col,row} code,
//     used when KEYPAD_HEX_MAP_EN is defined.
package keypad_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESSED = 1'b1;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } scan_res_t;

  localparam scan_res_t RES_NONE = '{valid: 1'b0, code: 4'h0};

  // Entry [col*4 + row] is the character printed on that key.
  localparam logic [3:0] HEX_LEGEND [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,   // column 0
    4'h2, 4'h5, 4'h8, 4'hF,   // column 1
    4'h3, 4'h6, 4'h9, 4'hE,   // column 2
    4'hA, 4'hB, 4'hC, 4'hD    // column 3
  };

  function automatic logic [3:0] hex_map(input logic [3:0] raw);
    return HEX_LEGEND[raw];
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: whole-scan debounce and press/release event generation.
// Optional feature: KEYPAD_HEX_MAP_EN translates the committed code to the
// printed key legend before it is registered; otherwise the raw code is kept.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   scan_end_i       one-cycle strobe on the column-3 sample cycle
//   res_valid_i      scan result has a key (qualified by scan_end_i)
//   res_code_i       raw {col,row} code of the scan result
//   key_code_o       committed key code, held after release
//   key_valid_o      high while a debounced key is held
//   key_pressed_o    one-cycle pulse when a new key is committed
//   key_released_o   one-cycle pulse when the held key is released
import keypad_pkg::*;

module keypad_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_end_i,
  input  logic       res_valid_i,
  input  logic [3:0] res_code_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_pressed_o,
  output logic       key_released_o
);

  localparam logic [3:0] CNT_MAX = DEBOUNCE_SCANS[3:0];

  scan_res_t  prev_q, prev_d;
  logic [3:0] cnt_q, cnt_d;
  logic [0:0] state_q, state_d;
  logic [3:0] raw_q, raw_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       pressed_q, pressed_d;
  logic       released_q, released_d;
  scan_res_t  cur;
  logic [3:0] mapped;

  assign cur = '{valid: res_valid_i, code: res_code_i};

`ifdef KEYPAD_HEX_MAP_EN
  assign mapped = hex_map(res_code_i);
`else
  assign mapped = res_code_i;
`endif

  always_comb begin
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    raw_d      = raw_q;
    code_d     = code_q;
    valid_d    = valid_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    if (scan_end_i) begin
      if (cur == prev_q) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 4'd1;
      end else begin
        cnt_d  = 4'd1;
        prev_d = cur;
      end
      // Acts only on the new (post-update) count; a key already committed
      // matches raw_q, so a saturated count never re-fires.
      if (cnt_d == CNT_MAX) begin
        if (state_q == ST_IDLE) begin
          if (cur.valid) begin
            state_d   = ST_PRESSED;
            raw_d     = cur.code;
            code_d    = mapped;
            valid_d   = 1'b1;
            pressed_d = 1'b1;
          end
        end else begin
          if (!cur.valid) begin
            state_d    = ST_IDLE;
            valid_d    = 1'b0;
            released_d = 1'b1;
          end else if (cur.code != raw_q) begin
            raw_d     = cur.code;
            code_d    = mapped;
            pressed_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= RES_NONE;
      cnt_q      <= 4'd0;
      state_q    <= ST_IDLE;
      raw_q      <= 4'd0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      raw_q      <= raw_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign key_code_o     = code_q;
  assign key_valid_o    = valid_q;
  assign key_pressed_o  = pressed_q;
  assign key_released_o = released_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner (Pmod KYPD style).
// Drives one column low at a time, samples the synchronized rows at the end
// of each column slot, keeps the first pressed key of the scan (column then
// row ascending) and hands the scan result to keypad_debounce.
// Optional feature: KEYPAD_HEX_MAP_EN (legend-mapped key_code, see
// keypad_debounce); the default build reports the raw {col,row} code.
// Ports:
//   clk           system clock
//   rst_n         async active-low reset
//   row_n[3:0]    keypad rows, active-low, asynchronous to clk
//   col_n[3:0]    column drive, active-low one-hot, registered
//   key_code[3:0] committed key code
//   key_valid     debounced key held
//   key_pressed   new-key pulse
//   key_released  release pulse
import keypad_pkg::*;

module keypad_scanner #(
  parameter int SCAN_TICKS     = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed,
  output logic       key_released
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);

  logic [TW-1:0] tick_q;
  logic [1:0]    col_idx_q;
  logic [1:0]    col_nxt;
  logic [3:0]    col_n_q;
  logic [3:0]    row_s1_q, row_s2_q;
  scan_res_t     acc_q;
  scan_res_t     found;
  scan_res_t     merged;
  logic [3:0]    rows_low;
  logic          sample;
  logic          scan_end;

  assign sample   = (tick_q == TICK_LAST);
  assign scan_end = sample && (col_idx_q == 2'd3);
  assign rows_low = ~row_s2_q;
  assign col_nxt  = col_idx_q + 2'd1;

  always_comb begin
    found = RES_NONE;
    if (rows_low[0])      found = '{valid: 1'b1, code: {col_idx_q, 2'd0}};
    else if (rows_low[1]) found = '{valid: 1'b1, code: {col_idx_q, 2'd1}};
    else if (rows_low[2]) found = '{valid: 1'b1, code: {col_idx_q, 2'd2}};
    else if (rows_low[3]) found = '{valid: 1'b1, code: {col_idx_q, 2'd3}};
  end

  // Column 0 starts a fresh scan; later columns only fill an empty result.
  assign merged = ((col_idx_q == 2'd0) || !acc_q.valid) ? found : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q  <= 4'hF;
      row_s2_q  <= 4'hF;
      tick_q    <= '0;
      col_idx_q <= 2'd0;
      col_n_q   <= 4'b1110;
      acc_q     <= RES_NONE;
    end else begin
      row_s1_q <= row_n;
      row_s2_q <= row_s1_q;
      if (sample) begin
        tick_q    <= '0;
        col_idx_q <= col_nxt;
        col_n_q   <= ~(4'b0001 << col_nxt);
        acc_q     <= merged;
      end else begin
        tick_q <= tick_q + 1'b1;
      end
    end
  end

  assign col_n = col_n_q;

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk           (clk),
    .rst_n         (rst_n),
    .scan_end_i    (scan_end),
    .res_valid_i   (merged.valid),
    .res_code_i    (merged.code),
    .key_code_o    (key_code),
    .key_valid_o   (key_valid),
    .key_pressed_o (key_pressed),
    .key_released_o(key_released)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_TICKS=4, DEBOUNCE_SCANS=2 (16-cycle scan).
// Keys change only at scan starts, so each scan sees one constant key set.
module tb_keypad_scanner;

  localparam int ST = 4;
  localparam int DS = 2;
  localparam int SCAN = 4 * ST;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;
  logic       key_released;

  logic [15:0] key_mat = 16'h0;   // bit col*4+row set = key held

  int n_checks = 0;
  int n_fail   = 0;

  logic       hold_valid = 1'b0;
  logic [3:0] hold_code  = 4'h0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_pressed (key_pressed),
    .key_released(key_released)
  );

  // Passive matrix: a held key shorts its row to a column driven low.
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col_n[c])
        for (int r = 0; r < 4; r++)
          if (key_mat[c*4 + r]) row_n[r] = 1'b0;
  end

  typedef struct {
    logic [15:0] keys;
    logic        ev;
    int          ek;   // raw key index of expected key_code, -1 = never committed
    logic        ep;
    logic        er;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(logic [15:0] k, logic v, int e, logic p, logic r);
    vec_t x;
    x.keys = k; x.ev = v; x.ek = e; x.ep = p; x.er = r;
    return x;
  endfunction

  function automatic logic [3:0] exp_code(input int k);
    int col, row;
    logic [15:0] legend [4];
    logic [15:0] line;
    if (k < 0) return 4'h0;
    col = k / 4;
    row = k % 4;
    legend[0] = 16'h123A;
    legend[1] = 16'h456B;
    legend[2] = 16'h789C;
    legend[3] = 16'h0FED;
    line = legend[row];
`ifdef KEYPAD_HEX_MAP_EN
    return line[15 - 4*col -: 4];
`else
    if (line == 16'h0) return 4'h0;   // keeps the legend table referenced
    return 4'((col << 2) | row);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the negedge of a scan's first cycle; returns at the first
  // cycle of the next scan after checking the scan-end effects.
  task automatic do_scan(input logic [15:0] keys, input logic ev, input int ek,
                         input logic ep, input logic er);
    logic [3:0] ec;
    key_mat = keys;
    for (int t = 1; t < SCAN; t++) begin
      @(negedge clk);
      ec = ~(4'b0001 << (t / ST));
      chk("col_n", int'(col_n), int'(ec));
      chk("pressed_quiet", int'(key_pressed), 0);
      chk("released_quiet", int'(key_released), 0);
      chk("valid_hold", int'(key_valid), int'(hold_valid));
      chk("code_hold", int'(key_code), int'(hold_code));
    end
    @(negedge clk);
    chk("col_n_wrap", int'(col_n), int'(4'b1110));
    chk("key_valid", int'(key_valid), int'(ev));
    chk("key_code", int'(key_code), int'(exp_code(ek)));
    chk("key_pressed", int'(key_pressed), int'(ep));
    chk("key_released", int'(key_released), int'(er));
    hold_valid = ev;
    hold_code  = exp_code(ek);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_col_n", int'(col_n), int'(4'b1110));
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_code", int'(key_code), 0);
    chk("rst_pressed", int'(key_pressed), 0);
    chk("rst_released", int'(key_released), 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_pressed", int'(key_pressed), 0);
      chk("rst_hold_col_n", int'(col_n), int'(4'b1110));
    end
    rst_n = 1'b1;
    hold_valid = 1'b0;
    hold_code  = 4'h0;
  endtask

  // Scan-level reference model state
  int   m_prev, m_cnt, m_key;
  logic m_valid;

  initial begin
    logic [15:0] keys;
    logic [15:0] pick;
    int res;
    logic ep, er;

    for (int i = 0; i < 10; i++) vecs[i] = mk(16'h0000, 1'b0, -1, 1'b0, 1'b0);
    vecs[10] = mk(16'h0040, 1'b0, -1, 1'b0, 1'b0);  // col1,row2: first scan
    vecs[11] = mk(16'h0040, 1'b1,  6, 1'b1, 1'b0);  // commit after 2 scans
    vecs[12] = mk(16'h0040, 1'b1,  6, 1'b0, 1'b0);
    vecs[13] = mk(16'h0000, 1'b1,  6, 1'b0, 1'b0);  // one-scan bounce
    vecs[14] = mk(16'h0040, 1'b1,  6, 1'b0, 1'b0);
    vecs[15] = mk(16'h0040, 1'b1,  6, 1'b0, 1'b0);  // same key, no re-fire
    vecs[16] = mk(16'h0000, 1'b1,  6, 1'b0, 1'b0);
    vecs[17] = mk(16'h0000, 1'b0,  6, 1'b0, 1'b1);  // release
    vecs[18] = mk(16'h0000, 1'b0,  6, 1'b0, 1'b0);
    vecs[19] = mk(16'h0108, 1'b0,  6, 1'b0, 1'b0);  // col0/row3 + col2/row0
    vecs[20] = mk(16'h0108, 1'b1,  3, 1'b1, 1'b0);  // col0 wins
    vecs[21] = mk(16'h0100, 1'b1,  3, 1'b0, 1'b0);
    vecs[22] = mk(16'h0100, 1'b1,  8, 1'b1, 1'b0);  // key change, no release
    vecs[23] = mk(16'h0100, 1'b1,  8, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    do_reset();

    for (int i = 0; i < 24; i++)
      do_scan(vecs[i].keys, vecs[i].ev, vecs[i].ek, vecs[i].ep, vecs[i].er);

    // Reset in the middle of a held press
    key_mat = 16'h0100;
    repeat (5) @(negedge clk);
    do_reset();
    do_scan(16'h0100, 1'b0, -1, 1'b0, 1'b0);
    do_scan(16'h0100, 1'b1,  8, 1'b1, 1'b0);

    // Randomized scans against the scan-level model
    key_mat = 16'h0;
    @(negedge clk);
    do_reset();
    m_prev = -1; m_cnt = 0; m_key = -1; m_valid = 1'b0;
    keys = 16'h0;
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 1) == 0) begin
        keys = 16'h0;
        repeat ($urandom_range(0, 2)) begin
          pick = 16'h0001 << $urandom_range(0, 15);
          keys = keys | pick;
        end
      end
      res = -1;
      for (int i = 15; i >= 0; i--) if (keys[i]) res = i;
      if (res == m_prev) begin
        if (m_cnt < DS) m_cnt++;
      end else begin
        m_cnt = 1;
        m_prev = res;
      end
      ep = 1'b0; er = 1'b0;
      if (m_cnt == DS) begin
        if (!m_valid && res >= 0) begin
          m_valid = 1'b1; m_key = res; ep = 1'b1;
        end else if (m_valid && res < 0) begin
          m_valid = 1'b0; er = 1'b1;
        end else if (m_valid && res != m_key) begin
          m_key = res; ep = 1'b1;
        end
      end
      do_scan(keys, m_valid, m_key, ep, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
